mem_copy: RTL and testbench

Bus initiator that drives the single-port synchronous `ram` port (`cs`/`write`/`addr`/`data_in`/`data_out`, one-cycle registered read) to copy a block of words from a source address range to a destination range in the same RAM. It sits between the system controller and the RAM, taking ownership of the memory port while `busy` or `done` is high. It provides a start/busy/done handshake toward the controller.

---
 rtl/mem_copy_if.sv | 32 +++
 rtl/mem_copy.sv | 116 +++++++++++
 tb/tb_mem_copy.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_copy_if.sv
// mem_copy_if: groups the controller handshake and the RAM port of mem_copy.
//   start/src/dst/len : copy request from the system controller
//   busy/done         : transfer status back to the controller
//   mem_cs/mem_write/mem_addr/mem_wdata : strobes toward the single-port RAM
//   mem_rdata         : RAM read data, valid the cycle after a read strobe
// Modport master is the copy engine; slave is the controller/RAM side.
interface mem_copy_if #(
  parameter int A = 10,
  parameter int D = 8
);
  logic         start;
  logic [A-1:0] src;
  logic [A-1:0] dst;
  logic [A:0]   len;
  logic         busy;
  logic         done;
  logic         mem_cs;
  logic         mem_write;
  logic [A-1:0] mem_addr;
  logic [D-1:0] mem_wdata;
  logic [D-1:0] mem_rdata;

  modport master (
    input  start, src, dst, len, mem_rdata,
    output busy, done, mem_cs, mem_write, mem_addr, mem_wdata
  );

  modport slave (
    output start, src, dst, len, mem_rdata,
    input  busy, done, mem_cs, mem_write, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_copy.sv
// mem_copy: copies len words from src.. to dst.. inside one single-port RAM,
// one word at a time (read, latch, write), ascending, addresses wrapping
// modulo 2^A.
// Ports:
//   clk   : system clock, rising edge
//   reset : synchronous, active-high
//   bus   : mem_copy_if.master (controller handshake + RAM port)
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for start; all outputs low/zero
// READ  | read strobe at src+i
// LATCH | RAM returns data; captured into buffer at end of cycle
// WRITE | write strobe of buffer to dst+i; advance i
// DONE  | one-cycle completion pulse
module mem_copy #(
  parameter int A = 10,
  parameter int D = 8
) (
  input logic         clk,
  input logic         reset,
  mem_copy_if.master  bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    LATCH = 3'd2,
    WRITE = 3'd3,
    DONE  = 3'd4
  } state_e;

  state_e       state_q, state_d;
  logic [A-1:0] src_q, src_d;
  logic [A-1:0] dst_q, dst_d;
  logic [A:0]   len_q, len_d;
  logic [A:0]   idx_q, idx_d;
  logic [D-1:0] buf_q, buf_d;

  logic [A:0]   idx_inc;

  // idx never exceeds len-1, so idx+1 fits in A+1 bits.
  assign idx_inc = idx_q + 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      len_q   <= '0;
      idx_q   <= '0;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      buf_q   <= buf_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    src_d         = src_q;
    dst_d         = dst_q;
    len_d         = len_q;
    idx_d         = idx_q;
    buf_d         = buf_q;
    bus.busy      = 1'b0;
    bus.done      = 1'b0;
    bus.mem_cs    = 1'b0;
    bus.mem_write = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          src_d   = bus.src;
          dst_d   = bus.dst;
          len_d   = bus.len;
          idx_d   = '0;
          state_d = (bus.len != '0) ? READ : DONE;
        end
      end
      READ: begin
        bus.busy     = 1'b1;
        bus.mem_cs   = 1'b1;
        // Low A bits of the index give modulo-2^A wrap for free.
        bus.mem_addr = src_q + idx_q[A-1:0];
        state_d      = LATCH;
      end
      LATCH: begin
        bus.busy = 1'b1;
        buf_d    = bus.mem_rdata;
        state_d  = WRITE;
      end
      WRITE: begin
        bus.busy      = 1'b1;
        bus.mem_cs    = 1'b1;
        bus.mem_write = 1'b1;
        bus.mem_addr  = dst_q + idx_q[A-1:0];
        bus.mem_wdata = buf_q;
        idx_d         = idx_inc;
        state_d       = (idx_inc < len_q) ? READ : DONE;
      end
      DONE: begin
        bus.done = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_copy.sv
module tb_mem_copy;
  localparam int A = 10;
  localparam int D = 8;

  logic clk;
  logic reset;

  mem_copy_if #(.A(A), .D(D)) bus ();

  mem_copy #(.A(A), .D(D)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // RAM model with one-cycle registered read plus a bench preload port.
  logic [D-1:0] ram [0:(1<<A)-1];
  logic [D-1:0] rd_q;
  logic         pl_we;
  logic [A-1:0] pl_addr;
  logic [D-1:0] pl_data;

  always @(posedge clk) begin
    if (pl_we) ram[pl_addr] <= pl_data;
    else if (bus.mem_cs) begin
      if (bus.mem_write) ram[bus.mem_addr] <= bus.mem_wdata;
      else rd_q <= ram[bus.mem_addr];
    end
  end
  assign bus.mem_rdata = rd_q;

  int n_checks = 0;
  int n_fail   = 0;

  // observation results filled by observe()
  int busy_cnt, busy_first, busy_last, done_cnt, done_cyc, cs_cnt, idle_nz;
  int rst_zero;
  logic [A-1:0] rd_addrs[$];
  logic [A-1:0] wr_addrs[$];

  task automatic preload(input logic [A-1:0] a, input logic [D-1:0] d);
    @(negedge clk);
    pl_we = 1'b1; pl_addr = a; pl_data = d;
    @(posedge clk); #1;
    pl_we = 1'b0;
  endtask

  task automatic do_start(input logic [A-1:0] s, input logic [A-1:0] d, input logic [A:0] l);
    @(negedge clk);
    bus.start = 1'b1; bus.src = s; bus.dst = d; bus.len = l;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  // Samples cycles 1..ncyc after the accepting edge at mid-cycle.
  // ign_cyc: raise a stray start during that cycle; rst_cyc: assert reset
  // during that cycle (0 disables either).
  task automatic observe(input int ncyc, input int ign_cyc, input int rst_cyc);
    busy_cnt = 0; busy_first = 0; busy_last = 0; done_cnt = 0; done_cyc = 0;
    cs_cnt = 0; idle_nz = 0; rst_zero = -1;
    rd_addrs.delete(); wr_addrs.delete();
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clk);
      if (bus.busy) begin
        busy_cnt++;
        if (busy_first == 0) busy_first = c;
        busy_last = c;
      end
      if (bus.done) begin
        done_cnt++;
        if (done_cyc == 0) done_cyc = c;
      end
      if (bus.mem_cs) begin
        cs_cnt++;
        if (bus.mem_write) wr_addrs.push_back(bus.mem_addr);
        else rd_addrs.push_back(bus.mem_addr);
      end else if (bus.mem_addr != '0 || bus.mem_wdata != '0) begin
        idle_nz++;
      end
      if (ign_cyc != 0 && c == ign_cyc) begin
        bus.start = 1'b1; bus.src = 10'h200; bus.dst = 10'h300; bus.len = 11'd2;
      end
      if (ign_cyc != 0 && c == ign_cyc + 1) bus.start = 1'b0;
      if (rst_cyc != 0 && c == rst_cyc) begin
        reset = 1'b1;
        busy_cnt = 0; done_cnt = 0; cs_cnt = 0;
      end
      if (rst_cyc != 0 && c == rst_cyc + 1) begin
        rst_zero = (bus.busy === 1'b0 && bus.done === 1'b0 && bus.mem_cs === 1'b0 &&
                    bus.mem_write === 1'b0 && bus.mem_addr === '0 &&
                    bus.mem_wdata === '0) ? 1 : 0;
        reset = 1'b0;
      end
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({bus.busy, bus.done, bus.mem_cs, bus.mem_write} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_strobes: got %b expected 0000", {bus.busy, bus.done, bus.mem_cs, bus.mem_write});
    end
    n_checks++;
    if (bus.mem_addr !== 10'h000 || bus.mem_wdata !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_bus: got addr %h wdata %h expected 000 00", bus.mem_addr, bus.mem_wdata);
    end
    reset = 1'b0;
  endtask

  task automatic test_basic;
    preload(10'h010, 8'hAA); preload(10'h011, 8'hBB);
    preload(10'h012, 8'hCC); preload(10'h013, 8'hDD);
    do_start(10'h010, 10'h100, 11'd4);
    observe(16, 0, 0);
    n_checks++;
    if (busy_cnt != 12 || busy_first != 1 || busy_last != 12) begin
      n_fail++;
      $display("FAIL basic_busy: got cnt %0d first %0d last %0d expected 12 1 12", busy_cnt, busy_first, busy_last);
    end
    n_checks++;
    if (done_cnt != 1 || done_cyc != 13) begin
      n_fail++;
      $display("FAIL basic_done: got cnt %0d cycle %0d expected 1 13", done_cnt, done_cyc);
    end
    n_checks++;
    if (rd_addrs.size() != 4 || rd_addrs[0] !== 10'h010 || rd_addrs[3] !== 10'h013 ||
        wr_addrs.size() != 4 || wr_addrs[0] !== 10'h100 || wr_addrs[3] !== 10'h103) begin
      n_fail++;
      $display("FAIL basic_addrs: got %0d reads %0d writes, expected 4 reads 010..013, 4 writes 100..103",
               rd_addrs.size(), wr_addrs.size());
    end
    n_checks++;
    if (idle_nz != 0) begin
      n_fail++;
      $display("FAIL basic_idle_bus: got %0d nonzero idle cycles expected 0", idle_nz);
    end
    n_checks++;
    if ({ram[10'h100], ram[10'h101], ram[10'h102], ram[10'h103]} !== 32'hAABBCCDD) begin
      n_fail++;
      $display("FAIL basic_data: got %h%h%h%h expected AABBCCDD",
               ram[10'h100], ram[10'h101], ram[10'h102], ram[10'h103]);
    end
  endtask

  task automatic test_zero_len;
    do_start(10'h010, 10'h120, 11'd0);
    observe(5, 0, 0);
    n_checks++;
    if (cs_cnt != 0 || busy_cnt != 0) begin
      n_fail++;
      $display("FAIL zero_len_activity: got cs %0d busy %0d expected 0 0", cs_cnt, busy_cnt);
    end
    n_checks++;
    if (done_cnt != 1 || done_cyc != 1) begin
      n_fail++;
      $display("FAIL zero_len_done: got cnt %0d cycle %0d expected 1 1", done_cnt, done_cyc);
    end
  endtask

  task automatic test_wrap;
    preload(10'h3FE, 8'h11); preload(10'h3FF, 8'h22); preload(10'h000, 8'h33);
    do_start(10'h3FE, 10'h001, 11'd3);
    observe(12, 0, 0);
    n_checks++;
    if (rd_addrs.size() != 3 || rd_addrs[0] !== 10'h3FE || rd_addrs[1] !== 10'h3FF ||
        rd_addrs[2] !== 10'h000) begin
      n_fail++;
      $display("FAIL wrap_rd_addrs: got %0d reads, expected 3FE 3FF 000", rd_addrs.size());
    end
    n_checks++;
    if ({ram[10'h001], ram[10'h002], ram[10'h003]} !== 24'h112233) begin
      n_fail++;
      $display("FAIL wrap_data: got %h%h%h expected 112233", ram[10'h001], ram[10'h002], ram[10'h003]);
    end
    n_checks++;
    if (done_cyc != 10) begin
      n_fail++;
      $display("FAIL wrap_done: got cycle %0d expected 10", done_cyc);
    end
  endtask

  task automatic test_overlap;
    preload(10'h000, 8'h5A); preload(10'h001, 8'hA5);
    do_start(10'h000, 10'h001, 11'd3);
    observe(12, 0, 0);
    n_checks++;
    if ({ram[10'h001], ram[10'h002], ram[10'h003]} !== 24'h5A5A5A) begin
      n_fail++;
      $display("FAIL overlap_data: got %h%h%h expected 5A5A5A", ram[10'h001], ram[10'h002], ram[10'h003]);
    end
  endtask

  task automatic test_ignored_start;
    preload(10'h200, 8'h01); preload(10'h201, 8'h02);
    do_start(10'h010, 10'h140, 11'd4);
    observe(24, 5, 0);
    n_checks++;
    if (done_cnt != 1 || done_cyc != 13 || busy_cnt != 12) begin
      n_fail++;
      $display("FAIL ignored_start_timing: got done %0d@%0d busy %0d expected 1@13 busy 12",
               done_cnt, done_cyc, busy_cnt);
    end
    n_checks++;
    if (rd_addrs.size() != 4 || rd_addrs[2] !== 10'h012 || wr_addrs.size() != 4) begin
      n_fail++;
      $display("FAIL ignored_start_accesses: got %0d reads %0d writes expected 4 4", rd_addrs.size(), wr_addrs.size());
    end
    n_checks++;
    if ({ram[10'h140], ram[10'h141], ram[10'h142], ram[10'h143]} !== 32'hAABBCCDD) begin
      n_fail++;
      $display("FAIL ignored_start_data: got %h%h%h%h expected AABBCCDD",
               ram[10'h140], ram[10'h141], ram[10'h142], ram[10'h143]);
    end
  endtask

  task automatic test_reset_mid;
    preload(10'h180, 8'hEE); preload(10'h181, 8'hEE);
    preload(10'h182, 8'hEE); preload(10'h183, 8'hEE);
    do_start(10'h010, 10'h180, 11'd4);
    observe(20, 0, 7);
    n_checks++;
    if (rst_zero != 1) begin
      n_fail++;
      $display("FAIL reset_mid_outputs: got all_zero=%0d expected 1", rst_zero);
    end
    n_checks++;
    if (done_cnt != 0 || cs_cnt != 0 || busy_cnt != 0) begin
      n_fail++;
      $display("FAIL reset_mid_quiet: got done %0d cs %0d busy %0d expected 0 0 0", done_cnt, cs_cnt, busy_cnt);
    end
    n_checks++;
    if ({ram[10'h180], ram[10'h181], ram[10'h182], ram[10'h183]} !== 32'hAABBEEEE) begin
      n_fail++;
      $display("FAIL reset_mid_data: got %h%h%h%h expected AABBEEEE",
               ram[10'h180], ram[10'h181], ram[10'h182], ram[10'h183]);
    end
    do_start(10'h012, 10'h190, 11'd2);
    observe(9, 0, 0);
    n_checks++;
    if (done_cnt != 1 || done_cyc != 7 || {ram[10'h190], ram[10'h191]} !== 16'hCCDD) begin
      n_fail++;
      $display("FAIL reset_mid_restart: got done %0d@%0d data %h%h expected 1@7 CCDD",
               done_cnt, done_cyc, ram[10'h190], ram[10'h191]);
    end
  endtask

  task automatic test_back_to_back;
    // Start accepted at the edge ending the first IDLE cycle after DONE.
    do_start(10'h010, 10'h1A0, 11'd1);
    observe(4, 0, 0);
    n_checks++;
    if (done_cyc != 4 || busy_cnt != 3) begin
      n_fail++;
      $display("FAIL b2b_first: got done@%0d busy %0d expected 4 3", done_cyc, busy_cnt);
    end
    // cycle 5 is IDLE; this start is sampled at the edge ending it
    do_start(10'h011, 10'h1A1, 11'd1);
    observe(5, 0, 0);
    n_checks++;
    if (done_cyc != 4 || {ram[10'h1A0], ram[10'h1A1]} !== 16'hAABB) begin
      n_fail++;
      $display("FAIL b2b_second: got done@%0d data %h%h expected 4 AABB", done_cyc, ram[10'h1A0], ram[10'h1A1]);
    end
  endtask

  initial begin
    reset = 1'b1;
    pl_we = 1'b0; pl_addr = '0; pl_data = '0;
    bus.start = 1'b0; bus.src = '0; bus.dst = '0; bus.len = '0;
    test_reset();
    test_basic();
    test_zero_len();
    test_wrap();
    test_overlap();
    test_ignored_start();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
